// File: rtl/nts_tx_header_writer_pkg.sv
// rtl/nts_tx_header_writer_pkg.sv - shared constants, state encoding and mask helper for the NTS TX header writer
package nts_tx_header_writer_pkg;

  localparam int NTP_HEADER_BLOCKS = 6;
  localparam int NTP_OFS_IPV4      = 42;
  localparam int NTP_OFS_IPV6      = 62;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Byte mask for word k of a realigned header; bit7 is the lowest-address byte.
  function automatic logic [7:0] word_mask(input logic [2:0] shift, input logic [2:0] k);
    if (k == 3'd0) begin
      return 8'hFF >> shift;
    end else if (k == 3'd6) begin
      return ~(8'hFF >> shift);
    end else begin
      return 8'hFF;
    end
  endfunction

endpackage

// File: rtl/nts_tx_header_writer.sv
// rtl/nts_tx_header_writer.sv - stages six NTP header blocks and writes them byte-realigned into the TX buffer
module nts_tx_header_writer
  import nts_tx_header_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_clear,
  input  logic                  i_wr_en,
  input  logic [2:0]            i_block,
  input  logic [63:0]           i_data,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH+2:0] i_byte_offset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_tx_write_en,
  input  logic                  i_tx_ready,
  output logic [ADDR_WIDTH-1:0] o_tx_addr,
  output logic [63:0]           o_tx_data,
  output logic [7:0]            o_tx_byte_mask
);

  localparam int HDR_BITS = 64 * NTP_HEADER_BLOCKS;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [HDR_BITS-1:0]     r_hdr;
  logic [HDR_BITS-1:0]     w_hdr_nx;
  logic [5:0]              r_valid;
  logic [5:0]              w_valid_nx;
  logic [ADDR_WIDTH-1:0]   r_word_addr;
  logic [ADDR_WIDTH-1:0]   w_word_addr_nx;
  logic [2:0]              r_shift;
  logic [2:0]              w_shift_nx;
  logic [2:0]              r_nwords;
  logic [2:0]              w_nwords_nx;
  logic [2:0]              r_k;
  logic [2:0]              w_k_nx;
  logic                    w_load_word;
  logic                    r_tx_write_en;
  logic                    w_tx_write_en_nx;
  logic                    r_done;
  logic                    w_done_nx;
  logic                    r_error;
  logic                    w_error_nx;
  logic [ADDR_WIDTH-1:0]   r_tx_addr;
  logic [63:0]             r_tx_data;
  logic [7:0]              r_tx_byte_mask;

  // Word k of ({slot0..slot5, 64'b0} >> 8*shift), taken from the top.
  function automatic logic [63:0] realign(input logic [HDR_BITS-1:0] hdr,
                                          input logic [2:0] shift,
                                          input logic [2:0] k);
    logic [HDR_BITS+63:0] w;
    w = {hdr, 64'b0} >> {shift, 3'b000};
    w = w << {k, 6'b000000};
    return w[HDR_BITS+63 -: 64];
  endfunction

  always_comb begin
    w_state_nx       = r_state;
    w_hdr_nx         = r_hdr;
    w_valid_nx       = r_valid;
    w_word_addr_nx   = r_word_addr;
    w_shift_nx       = r_shift;
    w_nwords_nx      = r_nwords;
    w_k_nx           = r_k;
    w_load_word      = 1'b0;
    w_tx_write_en_nx = r_tx_write_en;
    w_done_nx        = 1'b0;
    w_error_nx       = 1'b0;

    if (i_clear) begin
      w_state_nx       = ST_IDLE;
      w_valid_nx       = '0;
      w_tx_write_en_nx = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_wr_en) begin
            if (i_block < 3'(NTP_HEADER_BLOCKS)) begin
              for (int n = 0; n < NTP_HEADER_BLOCKS; n++) begin
                if (i_block == 3'(n)) begin
                  w_hdr_nx[HDR_BITS-1-64*n -: 64] = i_data;
                  w_valid_nx[n]                   = 1'b1;
                end
              end
            end else begin
              w_error_nx = 1'b1;
            end
          end
          // Acceptance looks only at r_valid so a same-cycle capture cannot complete the set.
          if (i_start) begin
            if (&r_valid) begin
              w_state_nx       = ST_EMIT;
              w_word_addr_nx   = i_byte_offset[ADDR_WIDTH+2:3];
              w_shift_nx       = i_byte_offset[2:0];
              w_nwords_nx      = (i_byte_offset[2:0] == 3'd0) ? 3'd6 : 3'd7;
              w_k_nx           = 3'd0;
              w_tx_write_en_nx = 1'b1;
              w_load_word      = 1'b1;
            end else begin
              w_error_nx = 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (i_wr_en) begin
            w_error_nx = 1'b1;
          end
          if (r_tx_write_en && i_tx_ready) begin
            if (r_k == r_nwords - 3'd1) begin
              w_state_nx       = ST_IDLE;
              w_valid_nx       = '0;
              w_tx_write_en_nx = 1'b0;
              w_done_nx        = 1'b1;
            end else begin
              w_k_nx      = r_k + 3'd1;
              w_load_word = 1'b1;
            end
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge i_clk) begin
    r_hdr <= w_hdr_nx;
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_valid        <= '0;
      r_word_addr    <= '0;
      r_shift        <= '0;
      r_nwords       <= '0;
      r_k            <= '0;
      r_tx_write_en  <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_tx_addr      <= '0;
      r_tx_data      <= '0;
      r_tx_byte_mask <= '0;
    end else begin
      r_valid       <= w_valid_nx;
      r_word_addr   <= w_word_addr_nx;
      r_shift       <= w_shift_nx;
      r_nwords      <= w_nwords_nx;
      r_k           <= w_k_nx;
      r_tx_write_en <= w_tx_write_en_nx;
      r_done        <= w_done_nx;
      r_error       <= w_error_nx;
      if (w_load_word) begin
        r_tx_addr      <= w_word_addr_nx + {{(ADDR_WIDTH-3){1'b0}}, w_k_nx};
        r_tx_data      <= realign(w_hdr_nx, w_shift_nx, w_k_nx);
        r_tx_byte_mask <= word_mask(w_shift_nx, w_k_nx);
      end
    end
  end

  assign o_busy         = (r_state == ST_EMIT);
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_tx_write_en  = r_tx_write_en;
  assign o_tx_addr      = r_tx_addr;
  assign o_tx_data      = r_tx_data;
  assign o_tx_byte_mask = r_tx_byte_mask;

endmodule

// File: tb/tb_nts_tx_header_writer.sv
// tb/tb_nts_tx_header_writer.sv - self-checking bench for nts_tx_header_writer with a byte-level reference model
module tb_nts_tx_header_writer;

  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          i_clear;
  logic          i_wr_en;
  logic [2:0]    i_block;
  logic [63:0]   i_data;
  logic          i_start;
  logic [AW+2:0] i_byte_offset;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic          o_tx_write_en;
  logic          i_tx_ready;
  logic [AW-1:0] o_tx_addr;
  logic [63:0]   o_tx_data;
  logic [7:0]    o_tx_byte_mask;

  int n_cmp;
  int n_fail;

  logic [63:0] m_slot [6];

  nts_tx_header_writer #(.ADDR_WIDTH(AW)) dut (
    .i_clk          (clk),
    .i_areset       (rst),
    .i_clear        (i_clear),
    .i_wr_en        (i_wr_en),
    .i_block        (i_block),
    .i_data         (i_data),
    .i_start        (i_start),
    .i_byte_offset  (i_byte_offset),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_tx_write_en  (o_tx_write_en),
    .i_tx_ready     (i_tx_ready),
    .o_tx_addr      (o_tx_addr),
    .o_tx_data      (o_tx_data),
    .o_tx_byte_mask (o_tx_byte_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hdr_byte(input int j);
    logic [63:0] s;
    s = m_slot[j / 8];
    return s[63 - 8 * (j % 8) -: 8];
  endfunction

  task automatic capture(input logic [2:0] blk, input logic [63:0] d, input string tag);
    @(negedge clk);
    i_wr_en = 1'b1;
    i_block = blk;
    i_data  = d;
    @(posedge clk);
    @(negedge clk);
    i_wr_en = 1'b0;
    check({tag, "_err"}, 64'(o_error), 64'(blk > 3'd5));
    if (blk <= 3'd5) m_slot[blk] = d;
  endtask

  task automatic capture_std(input string tag);
    for (int n = 0; n < 6; n++)
      capture(3'(n), 64'(n) + 64'h1111_0000_0000_0000 * 64'(n), tag);
  endtask

  task automatic capture_rand(input string tag);
    for (int n = 0; n < 6; n++)
      capture(3'(n), {$urandom, $urandom}, tag);
  endtask

  task automatic expect_refused(input logic [10:0] off, input string tag);
    @(negedge clk);
    i_start       = 1'b1;
    i_byte_offset = off;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_err"}, 64'(o_error), 64'd1);
    check({tag, "_we"}, 64'(o_tx_write_en), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_we2"}, 64'(o_tx_write_en), 64'd0);
  endtask

  // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic run_emit(input logic [10:0] off, input int mode, input int clear_after, input string tag);
    logic [7:0]  ea[$];
    logic [63:0] ed[$];
    logic [7:0]  em[$];
    int          first;
    int          last;
    int          acc;
    int          cyc;
    int          ph;
    int          nexp;
    bit          fin;
    bit          stalled;
    logic [7:0]  pa;
    logic [7:0]  pm;
    logic [63:0] pd;
    logic        rdy;
    logic [63:0] d;
    logic [7:0]  m;
    int          ba;

    first = int'(off) >> 3;
    last  = (int'(off) + 47) >> 3;
    for (int w = first; w <= last; w++) begin
      d = '0;
      m = '0;
      for (int b = 0; b < 8; b++) begin
        ba = w * 8 + b;
        if (ba >= int'(off) && ba < int'(off) + 48) begin
          m[7 - b] = 1'b1;
          d[63 - 8 * b -: 8] = hdr_byte(ba - int'(off));
        end
      end
      ea.push_back(8'(w));
      ed.push_back(d);
      em.push_back(m);
    end

    @(negedge clk);
    i_start       = 1'b1;
    i_byte_offset = off;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1; acc = 0; ph = 0; fin = 0; stalled = 0;
    pa = '0; pm = '0; pd = '0;
    while (!fin && cyc < 200) begin
      if (o_done) begin
        fin = 1;
        check({tag, "_done_noclear"}, 64'(clear_after >= 0), 64'd0);
        if (mode == 0) check({tag, "_done_cycle"}, 64'(cyc), 64'(ea.size() + 1));
        check({tag, "_we_at_done"}, 64'(o_tx_write_en), 64'd0);
      end else if (o_tx_write_en) begin
        if (stalled) begin
          check({tag, "_hold_addr"}, 64'(o_tx_addr), 64'(pa));
          check({tag, "_hold_data"}, o_tx_data, pd);
          check({tag, "_hold_mask"}, 64'(o_tx_byte_mask), 64'(pm));
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (ph % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        ph++;
        i_tx_ready = rdy;
        if (rdy) begin
          if (acc < ea.size()) begin
            check($sformatf("%s_addr%0d", tag, acc), 64'(o_tx_addr), 64'(ea[acc]));
            check($sformatf("%s_data%0d", tag, acc), o_tx_data, ed[acc]);
            check($sformatf("%s_mask%0d", tag, acc), 64'(o_tx_byte_mask), 64'(em[acc]));
          end else begin
            check({tag, "_extra_word"}, 64'(acc), 64'(ea.size() - 1));
          end
          acc++;
          stalled = 0;
          if (acc == clear_after) begin
            i_clear = 1'b1;
            @(posedge clk);
            @(negedge clk);
            i_clear = 1'b0;
            cyc++;
            check({tag, "_clr_we"}, 64'(o_tx_write_en), 64'd0);
            check({tag, "_clr_done"}, 64'(o_done), 64'd0);
            check({tag, "_clr_busy"}, 64'(o_busy), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_clr_done2"}, 64'(o_done), 64'd0);
            fin = 1;
          end
        end else begin
          stalled = 1;
          pa = o_tx_addr;
          pd = o_tx_data;
          pm = o_tx_byte_mask;
        end
      end
      if (!fin) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    i_tx_ready = 1'b1;
    nexp = (clear_after >= 0) ? clear_after : ea.size();
    check({tag, "_finished"}, 64'(fin), 64'd1);
    check({tag, "_word_count"}, 64'(acc), 64'(nexp));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    i_clear = 1'b0;
    i_wr_en = 1'b0;
    i_block = '0;
    i_data = '0;
    i_start = 1'b0;
    i_byte_offset = '0;
    i_tx_ready = 1'b1;
    for (int n = 0; n < 6; n++) m_slot[n] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 64'(o_tx_write_en), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_err", 64'(o_error), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_addr", 64'(o_tx_addr), 64'd0);
    check("rst_data", o_tx_data, 64'd0);
    check("rst_mask", 64'(o_tx_byte_mask), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    capture_std("t1cap");
    run_emit(11'd64, 0, -1, "t1");

    capture_std("t2cap");
    run_emit(11'd42, 0, -1, "t2");

    capture_std("t3cap");
    run_emit(11'd62, 1, -1, "t3");

    for (int n = 0; n < 6; n++)
      if (n != 3) capture(3'(n), 64'hA5A5_0000_0000_0000 + 64'(n), "t4cap");
    expect_refused(11'd42, "t4ref");
    capture(3'd3, 64'hDEAD_BEEF_0000_0003, "t4cap3");
    run_emit(11'd42, 0, -1, "t4");

    capture_std("t5cap");
    run_emit(11'd42, 0, 3, "t5");
    expect_refused(11'd42, "t5ref");

    capture_rand("t6cap");
    capture(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, "t6bad");
    run_emit(11'd2045, 0, -1, "t6");

    for (int it = 0; it < 6; it++) begin
      capture_rand($sformatf("r%0dcap", it));
      run_emit(11'($urandom_range(0, 2047)), 2, -1, $sformatf("r%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
